// File: rtl/regfile_write_scheduler.sv
// Arbitrates the single RegisterFile write port between pipeline writeback (A) and a
// buffered long-latency result stream (B), and tracks pending B destinations for hazards.
module regfile_write_scheduler #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AValid,
  input  logic [4:0]  AAddr,
  input  logic [31:0] AData,
  output logic        AStall,
  input  logic        BValid,
  output logic        BReady,
  input  logic [4:0]  BAddr,
  input  logic [31:0] BData,
  input  logic        IssueValid,
  input  logic [4:0]  IssueAddr,
  output logic        IssueHazard,
  input  logic [4:0]  ReadAddr1,
  input  logic [4:0]  ReadAddr2,
  output logic        Hazard1,
  output logic        Hazard2,
  output logic        WriteEn,
  output logic [4:0]  WriteAddr,
  output logic [31:0] WriteData
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  // Handshake: a B result transfers on a rising edge where BValid && BReady are both high;
  // BReady depends only on registered occupancy, never on the same-cycle dequeue.

  logic [4:0]    addr_mem_q [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   busy_q, busy_d;

  logic          fifo_ne, fifo_full, wait_sat;
  logic          a_eff, grant_a, grant_b;
  logic          b_acc, enq, issue_ok;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  assign fifo_ne   = (count_q != '0);
  assign fifo_full = (count_q == CW'(DEPTH));
  assign wait_sat  = (wait_q == WW'(MAX_WAIT));
  assign head_addr = addr_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  assign a_eff    = AValid && (AAddr != 5'd0);
  assign grant_b  = !rst && fifo_ne && (wait_sat || !a_eff);
  assign grant_a  = !rst && !grant_b && a_eff;

  assign BReady   = !rst && !fifo_full;
  assign b_acc    = BValid && BReady;
  assign enq      = b_acc && (BAddr != 5'd0);
  assign AStall   = !rst && a_eff && fifo_ne && wait_sat;

  assign issue_ok    = IssueValid && !busy_q[IssueAddr] && (IssueAddr != 5'd0);
  assign IssueHazard = !rst && IssueValid && busy_q[IssueAddr];
  assign Hazard1     = !rst && busy_q[ReadAddr1];
  assign Hazard2     = !rst && busy_q[ReadAddr2];

  always_comb begin
    WriteEn   = 1'b0;
    WriteAddr = '0;
    WriteData = '0;
    if (grant_b) begin
      WriteEn   = 1'b1;
      WriteAddr = head_addr;
      WriteData = head_data;
    end else if (grant_a) begin
      WriteEn   = 1'b1;
      WriteAddr = AAddr;
      WriteData = AData;
    end
  end

  always_comb begin
    rd_ptr_d = grant_b ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (enq && !grant_b)      count_d = count_q + CW'(1);
    else if (!enq && grant_b) count_d = count_q - CW'(1);
    // A fresh head always starts its deferral window from zero.
    wait_d = wait_q;
    if (!fifo_ne || grant_b) wait_d = '0;
    else if (!wait_sat)      wait_d = wait_q + WW'(1);
    // Busy stays visible through the grant cycle and clears at the writing edge.
    busy_d = busy_q;
    if (grant_b)  busy_d[head_addr] = 1'b0;
    if (issue_ok) busy_d[IssueAddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      busy_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem_q[wr_ptr_q] <= BAddr;
      data_mem_q[wr_ptr_q] <= BData;
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the arbitration and scoreboard rules.
module tb_regfile_write_scheduler;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        AValid, BValid, IssueValid;
  logic [4:0]  AAddr, BAddr, IssueAddr, ReadAddr1, ReadAddr2;
  logic [31:0] AData, BData;
  logic        AStall, BReady, IssueHazard, Hazard1, Hazard2, WriteEn;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;

  always #5 clk = ~clk;

  regfile_write_scheduler #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .AValid(AValid), .AAddr(AAddr), .AData(AData), .AStall(AStall),
    .BValid(BValid), .BReady(BReady), .BAddr(BAddr), .BData(BData),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr), .IssueHazard(IssueHazard),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .Hazard1(Hazard1), .Hazard2(Hazard2),
    .WriteEn(WriteEn), .WriteAddr(WriteAddr), .WriteData(WriteData)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: buffered B results in arrival order, deferral count, pending set.
  logic [36:0] exp_q[$];
  int          wait_m;
  logic [31:0] busy_m;
  int          out_q[$];

  logic        obs_we, obs_stall, obs_bready, obs_ihaz, obs_h1, obs_h2;
  logic [4:0]  obs_waddr;
  logic [31:0] obs_wdata;
  logic        a_stalled, b_accepted;
  logic        a_hold, b_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    AValid = 0; AAddr = 0; AData = 0;
    BValid = 0; BAddr = 0; BData = 0;
    IssueValid = 0; IssueAddr = 0;
    ReadAddr1 = 0; ReadAddr2 = 0;
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 time unit later,
  // the model advances at the rising edge, and the task returns at the next falling edge.
  task automatic step();
    logic        a_eff, ne, gb, ga;
    logic        e_we, e_stall, e_bready, e_ihaz, e_h1, e_h2;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [36:0] head;
    #1;
    obs_we = WriteEn; obs_waddr = WriteAddr; obs_wdata = WriteData;
    obs_stall = AStall; obs_bready = BReady; obs_ihaz = IssueHazard;
    obs_h1 = Hazard1; obs_h2 = Hazard2;
    a_eff = 0; ne = 0; gb = 0; ga = 0; head = '0;
    e_we = 0; e_wa = 0; e_wd = 0; e_stall = 0; e_bready = 0; e_ihaz = 0; e_h1 = 0; e_h2 = 0;
    if (!rst) begin
      a_eff = AValid && (AAddr != 0);
      ne    = (exp_q.size() != 0);
      if (ne) head = exp_q[0];
      gb = ne && ((wait_m == MAX_WAIT) || !a_eff);
      ga = !gb && a_eff;
      e_we = gb || ga;
      e_wa = gb ? head[36:32] : (ga ? AAddr : 5'd0);
      e_wd = gb ? head[31:0]  : (ga ? AData : 32'd0);
      e_stall  = a_eff && ne && (wait_m == MAX_WAIT);
      e_bready = (exp_q.size() < DEPTH);
      e_ihaz   = IssueValid && busy_m[IssueAddr];
      e_h1     = busy_m[ReadAddr1];
      e_h2     = busy_m[ReadAddr2];
    end
    check("write_en", obs_we, e_we);
    check("write_addr", obs_waddr, e_wa);
    check("write_data", obs_wdata, e_wd);
    check("a_stall", obs_stall, e_stall);
    check("b_ready", obs_bready, e_bready);
    check("issue_hazard", obs_ihaz, e_ihaz);
    check("hazard1", obs_h1, e_h1);
    check("hazard2", obs_h2, e_h2);
    @(posedge clk);
    a_stalled  = e_stall;
    b_accepted = !rst && BValid && e_bready;
    if (rst) begin
      exp_q.delete(); out_q.delete();
      wait_m = 0; busy_m = '0;
    end else begin
      if (!ne || gb) wait_m = 0;
      else if (wait_m < MAX_WAIT) wait_m++;
      if (gb) begin
        busy_m[head[36:32]] = 1'b0;
        void'(exp_q.pop_front());
      end
      if (IssueValid && !e_ihaz && IssueAddr != 0) begin
        busy_m[IssueAddr] = 1'b1;
        out_q.push_back(int'(IssueAddr));
      end
      if (b_accepted && BAddr != 0) exp_q.push_back({BAddr, BData});
    end
    @(negedge clk);
  endtask

  task automatic rand_cycle();
    int idx;
    logic [4:0] cand;
    rst = ($urandom_range(0, 299) == 0);
    if (!a_hold) begin
      AValid = ($urandom_range(0, 99) < 60);
      AData  = $urandom;
      if ($urandom_range(0, 9) == 0) AAddr = 0;
      else begin
        cand = 5'($urandom_range(1, 31));
        for (int k = 0; k < 32 && busy_m[cand]; k++) cand = 5'($urandom_range(1, 31));
        AAddr = cand;
        if (busy_m[cand]) AValid = 0;
      end
    end
    if (!b_hold) begin
      BValid = 0;
      if (out_q.size() > 0 && $urandom_range(0, 99) < 50) begin
        idx = $urandom_range(0, out_q.size() - 1);
        BAddr = 5'(out_q[idx]);
        out_q.delete(idx);
        BData = $urandom;
        BValid = 1;
      end else if ($urandom_range(0, 19) == 0) begin
        BAddr = 0; BData = $urandom; BValid = 1;
      end
    end
    IssueValid = ($urandom_range(0, 99) < 30);
    IssueAddr  = 5'($urandom_range(0, 31));
    if (AValid && IssueAddr == AAddr) IssueAddr = 0;
    ReadAddr1 = 5'($urandom_range(0, 31));
    ReadAddr2 = 5'($urandom_range(0, 31));
    step();
    a_hold = !rst && a_stalled;
    b_hold = !rst && BValid && !b_accepted;
  endtask

  initial begin
    int n_a;
    int cyc;
    logic [36:0] send_q[$];
    logic [4:0]  got_q[$];
    exp_q.delete(); out_q.delete();
    wait_m = 0; busy_m = '0; a_hold = 0; b_hold = 0;
    idle_inputs();
    rst = 1;
    @(negedge clk);

    AValid = 1; AAddr = 3; BValid = 1; BAddr = 4; IssueValid = 1; IssueAddr = 6;
    step(); step();
    check("rst_bready", obs_bready, 0);
    check("rst_we", obs_we, 0);
    idle_inputs();
    rst = 0;
    step();
    check("idle_bready", obs_bready, 1);
    check("idle_we", obs_we, 0);

    AValid = 1; AAddr = 7; AData = 25;
    repeat (3) begin
      step();
      check("a_only_addr", obs_waddr, 7);
      check("a_only_data", obs_wdata, 25);
      check("a_only_stall", obs_stall, 0);
    end
    idle_inputs();

    IssueValid = 1; IssueAddr = 9; ReadAddr1 = 9;
    step();
    IssueValid = 0; BValid = 1; BAddr = 9; BData = 40;
    step();
    check("x9_haz_accept", obs_h1, 1);
    BValid = 0; IssueValid = 1; IssueAddr = 9;
    step();
    check("x9_write_en", obs_we, 1);
    check("x9_write", obs_wdata, 40);
    check("x9_haz_grant", obs_h1, 1);
    check("x9_reissue", obs_ihaz, 1);
    IssueValid = 0;
    step();
    check("x9_haz_clear", obs_h1, 0);
    idle_inputs();

    IssueValid = 1; IssueAddr = 10;
    step();
    IssueValid = 0; BValid = 1; BAddr = 10; BData = 50;
    AValid = 1; AAddr = 5; AData = 77;
    step();
    BValid = 0;
    n_a = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_we && obs_waddr == 10) break;
      if (obs_we && obs_waddr == 5) n_a++;
    end
    check("starve_a_grants", n_a, MAX_WAIT);
    check("starve_b_data", obs_wdata, 50);
    check("starve_stall", obs_stall, 1);
    step();
    check("starve_resume", obs_wdata, 77);
    idle_inputs();

    for (int r = 11; r <= 13; r++) begin
      IssueValid = 1; IssueAddr = 5'(r);
      step();
    end
    IssueValid = 0;
    AValid = 1; AAddr = 5; AData = 88;
    for (int r = 11; r <= 13; r++) send_q.push_back({5'(r), 32'(r + 100)});
    cyc = 0;
    while (cyc < 40 && (send_q.size() > 0 || exp_q.size() > 0)) begin
      BValid = (send_q.size() > 0);
      if (BValid) {BAddr, BData} = send_q[0];
      step();
      if (cyc == 2) check("fill_bready_low", obs_bready, 0);
      if (obs_we && obs_waddr != 5) got_q.push_back(obs_waddr);
      if (b_accepted) void'(send_q.pop_front());
      cyc++;
    end
    check("fill_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check("fill_order", (i < got_q.size()) ? 32'(got_q[i]) : 32'hdead, 32'(11 + i));
    idle_inputs();

    AValid = 1; AAddr = 0; AData = 5;
    step();
    check("x0_a_we", obs_we, 0);
    check("x0_a_stall", obs_stall, 0);
    AValid = 0; BValid = 1; BAddr = 0; BData = 99;
    step();
    check("x0_b_ready", obs_bready, 1);
    BValid = 0;
    step();
    check("x0_b_we", obs_we, 0);

    IssueValid = 1; IssueAddr = 14; step();
    IssueAddr = 15; step();
    IssueValid = 0;
    AValid = 1; AAddr = 5; AData = 1;
    BValid = 1; BAddr = 14; BData = 140; step();
    BAddr = 15; BData = 150; step();
    BValid = 0;
    rst = 1;
    step();
    check("midrst_we", obs_we, 0);
    rst = 0; AValid = 0; ReadAddr1 = 14; ReadAddr2 = 15;
    step();
    check("midrst_h1", obs_h1, 0);
    check("midrst_h2", obs_h2, 0);
    check("midrst_we_after", obs_we, 0);
    check("midrst_bready", obs_bready, 1);
    step();
    check("midrst_no_write", obs_we, 0);

    a_hold = 0; b_hold = 0;
    for (int i = 0; i < 3000; i++) rand_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
